// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decoder, and services branch/jump redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redir_taken,
  input  logic        redir_jalr,
  input  logic [31:0] redir_base,
  input  logic [31:0] imm_ext,
  output logic        fetch_err
);

  // state  | meaning
  // IDLE   | post-reset gap, no request outstanding
  // REQ    | read request outstanding at imem_addr
  // HOLD   | instruction held for downstream, no request
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        drop_pend;
  logic [31:0] tgt_sum;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;
  logic        tgt_mis;

  assign tgt_sum = redir_base + imm_ext;
  assign tgt_raw = {tgt_sum[31:1], tgt_sum[0] & ~redir_jalr};
  assign tgt_mis = |tgt_raw[1:0];
  assign tgt     = {tgt_raw[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      drop_pend  <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          if (redir_taken) begin
            pc        <= tgt;
            imem_addr <= tgt;
            fetch_err <= tgt_mis;
          end else begin
            imem_addr <= pc;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            if (drop_pend || redir_taken) begin
              // stale data from an abandoned address; reissue at the current PC
              drop_pend <= 1'b0;
              if (redir_taken) begin
                pc        <= tgt;
                imem_addr <= tgt;
                fetch_err <= tgt_mis;
              end else begin
                imem_addr <= pc;
              end
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + 32'd4;
              imem_req   <= 1'b0;
              state      <= S_HOLD;
            end
          end else if (redir_taken) begin
            // address bus must stay put until the memory acks the old request
            pc        <= tgt;
            drop_pend <= 1'b1;
            fetch_err <= tgt_mis;
          end
        end
        S_HOLD: begin
          if (redir_taken || inst_ready) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            imem_req   <= 1'b1;
            state      <= S_REQ;
            if (redir_taken) begin
              pc        <= tgt;
              imem_addr <= tgt;
              fetch_err <= tgt_mis;
            end else begin
              imem_addr <= pc;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: scoreboarded fetches, stalls,
// redirects, dropped requests, misaligned targets, PC wrap and async reset.
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redir_taken = 1'b0;
  logic        redir_jalr = 1'b0;
  logic [31:0] redir_base = '0;
  logic [31:0] imm_ext = '0;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .redir_taken(redir_taken), .redir_jalr(redir_jalr),
    .redir_base(redir_base), .imm_ext(imm_ext),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // memory responder: waits for the request, acks after dly cycles, checks latency
  task automatic fetch_one(input logic [31:0] ea, input int dly);
    int n;
    logic [63:0] e;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    tests++;
    if (imem_req !== 1'b1) begin
      $display("FAIL req_timeout addr=%h: imem_req=%b required 1", ea, imem_req);
      fails++;
      return;
    end
    tests++;
    if (imem_addr !== ea) begin
      $display("FAIL req_addr: got %h required %h", imem_addr, ea);
      fails++;
    end
    repeat (dly) begin
      cyc();
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== ea) begin
        $display("FAIL req_stable: req=%b addr=%h required 1 %h", imem_req, imem_addr, ea);
        fails++;
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = data_of(imem_addr);
    sb.push_back({ea, data_of(ea)});
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    tests++;
    if (inst_valid !== 1'b1) begin
      $display("FAIL fetch_latency addr=%h: inst_valid=%b required 1", ea, inst_valid);
      fails++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (inst !== e[31:0] || inst_pc !== e[63:32]) begin
        $display("FAIL fetch_data: inst=%h pc=%h required %h %h", inst, inst_pc, e[31:0], e[63:32]);
        fails++;
      end
    end
  endtask

  task automatic do_redir(input logic [31:0] base, input logic [31:0] imm, input logic jalr);
    redir_taken = 1'b1;
    redir_jalr  = jalr;
    redir_base  = base;
    imm_ext     = imm;
    cyc();
    redir_taken = 1'b0;
    redir_jalr  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    repeat (2) cyc();
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst !== NOP || inst_pc !== 32'h0 ||
        inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
      $display("FAIL reset_state: req=%b addr=%h inst=%h pc=%h v=%b err=%b required 0 0 %h 0 0 0",
               imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_err, NOP);
      fails++;
    end
    rst_n = 1'b1;
    cyc();
    tests++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
      $display("FAIL first_req: req=%b v=%b addr=%h required 1 0 0", imem_req, inst_valid, imem_addr);
      fails++;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_sequential();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'(i * 4), 2);
      cyc();
      tests++;
      if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 || imem_addr !== 32'((i + 1) * 4)) begin
        $display("FAIL seq_consume %0d: v=%b inst=%h req=%b addr=%h required 0 %h 1 %h",
                 i, inst_valid, inst, imem_req, imem_addr, NOP, 32'((i + 1) * 4));
        fails++;
      end
    end
  endtask

  task automatic test_hold_stall();
    inst_ready = 1'b0;
    fetch_one(32'hC, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      tests++;
      if (inst_valid !== 1'b1 || inst !== data_of(32'hC) || inst_pc !== 32'hC || imem_req !== 1'b0) begin
        $display("FAIL hold_stable %0d: v=%b inst=%h pc=%h req=%b required 1 %h c 0",
                 i, inst_valid, inst, inst_pc, imem_req, data_of(32'hC));
        fails++;
      end
    end
  endtask

  task automatic test_branch_redirect();
    do_redir(32'h100, 32'h0, 1'b0);
    tests++;
    if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      $display("FAIL redir_hold: v=%b inst=%h req=%b addr=%h required 0 %h 1 100",
               inst_valid, inst, imem_req, imem_addr, NOP);
      fails++;
    end
    fetch_one(32'h100, 1);
    do_redir(32'h100, 32'hFFFF_FFF0, 1'b0);
    tests++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hF0 || fetch_err !== 1'b0) begin
      $display("FAIL redir_back: v=%b req=%b addr=%h err=%b required 0 1 f0 0",
               inst_valid, imem_req, imem_addr, fetch_err);
      fails++;
    end
    fetch_one(32'hF0, 0);
  endtask

  task automatic test_jalr();
    do_redir(32'h203, 32'h0, 1'b1);
    tests++;
    if (fetch_err !== 1'b1 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
      $display("FAIL jalr_misaligned: err=%b addr=%h req=%b required 1 200 1", fetch_err, imem_addr, imem_req);
      fails++;
    end
    cyc();
    tests++;
    if (fetch_err !== 1'b0) begin
      $display("FAIL err_pulse: err=%b required 0", fetch_err);
      fails++;
    end
    fetch_one(32'h200, 1);
    do_redir(32'h301, 32'h3, 1'b1);
    tests++;
    if (fetch_err !== 1'b0 || imem_addr !== 32'h304) begin
      $display("FAIL jalr_aligned: err=%b addr=%h required 0 304", fetch_err, imem_addr);
      fails++;
    end
    fetch_one(32'h304, 0);
  endtask

  task automatic test_drop();
    do_redir(32'h20, 32'h0, 1'b0);
    do_redir(32'h40, 32'h0, 1'b0);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      $display("FAIL drop_addr_hold1: req=%b addr=%h required 1 20", imem_req, imem_addr);
      fails++;
    end
    do_redir(32'h80, 32'h0, 1'b0);
    cyc();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      $display("FAIL drop_addr_hold2: req=%b addr=%h required 1 20", imem_req, imem_addr);
      fails++;
    end
    imem_ack   = 1'b1;
    imem_rdata = data_of(32'h20);
    cyc();
    imem_ack   = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      $display("FAIL drop_data: v=%b req=%b addr=%h required 0 1 80", inst_valid, imem_req, imem_addr);
      fails++;
    end
    fetch_one(32'h80, 2);
  endtask

  task automatic test_wrap();
    do_redir(32'hFFFF_FFFC, 32'h0, 1'b0);
    fetch_one(32'hFFFF_FFFC, 1);
    inst_ready = 1'b1;
    cyc();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin
      $display("FAIL pc_wrap: req=%b addr=%h err=%b required 1 0 0", imem_req, imem_addr, fetch_err);
      fails++;
    end
  endtask

  task automatic test_reset_mid_req();
    inst_ready = 1'b0;
    fetch_one(32'h0, 0);
    inst_ready = 1'b1;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst !== NOP || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin
      $display("FAIL async_reset: req=%b addr=%h inst=%h pc=%h v=%b required 0 0 %h 0 0",
               imem_req, imem_addr, inst, inst_pc, inst_valid, NOP);
      fails++;
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    rst_n = 1'b1;
    cyc();
    tests++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
      $display("FAIL ack_after_reset: req=%b v=%b addr=%h required 1 0 0", imem_req, inst_valid, imem_addr);
      fails++;
    end
    imem_ack = 1'b0;
    fetch_one(32'h0, 1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_branch_redirect();
    test_jalr();
    test_drop();
    test_wrap();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
